uart_tx_ctrl: RTL and testbench

Transmit-side sequencer for the UART TX path. Accepts a parallel byte with a valid strobe, serializes it LSB-first, computes the parity bit, and drives the 2-bit select of the TX output multiplexer so the line carries start, data, optional parity and stop bits in order. It sits between the system-side register/FIFO interface and the TX output mux, and runs in the TX baud clock domain at one bit per clock.

---
 rtl/uart_tx_ctrl.sv | 154 +++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl - transmit-side sequencer for the UART TX path.
//
// Accepts a parallel payload with a valid strobe. It serialises the payload
// LSB-first and drives the TX output mux select, so that the line carries:
// start, data, optional parity, stop. The block runs at one bit per CLK edge.
//
// Build option:
//   UART_TX_PARITY_EN - when defined, the PARITY state and the parity
//                       register are built. When undefined, par_bit is tied
//                       to 0, and PAR_EN/PAR_TYP are ignored.
//
// Ports:
//   CLK        TX baud clock, one rising edge per transmitted bit
//   RST        synchronous, active-high reset
//   P_DATA     parallel payload, DATA_WIDTH bits
//   Data_Valid payload-valid strobe (sampled in IDLE and STOP only)
//   PAR_EN     insert a parity bit for the frame being accepted
//   PAR_TYP    parity type: 0 = even, 1 = odd
//   mux_sel    TX mux select: 00 start, 01 stop/idle, 10 data, 11 parity
//   ser_data   current data bit (0 outside DATA)
//   par_bit    parity bit latched at acceptance
//   busy       frame in progress (START through STOP)
module uart_tx_ctrl #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [1:0]            mux_sel,
  output logic                  ser_data,
  output logic                  par_bit,
  output logic                  busy
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  logic                  accept;

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_en_d;
  logic par_q,    par_d;
`else
  logic unused_par_inputs;
  assign unused_par_inputs = PAR_EN ^ PAR_TYP;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
`ifdef UART_TX_PARITY_EN
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
`ifdef UART_TX_PARITY_EN
      par_en_q <= par_en_d;
      par_q    <= par_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d = par_en_q;
    par_d    = par_q;
`endif

    case (state_q)
      IDLE:  accept = Data_Valid;
      START: state_d = DATA;
      DATA: begin
        shift_d = shift_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
`ifdef UART_TX_PARITY_EN
          state_d = par_en_q ? PARITY : STOP;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: state_d = STOP;
`endif
      STOP: begin
        // A strobe in STOP chains straight into the next START, with no idle gap.
        accept = Data_Valid;
        if (!Data_Valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d  = START;
      shift_d  = P_DATA;
      cnt_d    = '0;
`ifdef UART_TX_PARITY_EN
      par_en_d = PAR_EN;
      par_d    = (^P_DATA) ^ PAR_TYP;
`endif
    end
  end

  // Outputs decode from registered state only.
  always_comb begin
    mux_sel  = 2'b01;
    ser_data = 1'b0;
    busy     = (state_q != IDLE);
    case (state_q)
      START: mux_sel = 2'b00;
      DATA: begin
        mux_sel  = 2'b10;
        ser_data = shift_q[0];
      end
`ifdef UART_TX_PARITY_EN
      PARITY: mux_sel = 2'b11;
`endif
      default: mux_sel = 2'b01;
    endcase
  end

`ifdef UART_TX_PARITY_EN
  assign par_bit = par_q;
`else
  assign par_bit = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl. A frame-level reference model queues
// the expected line symbols of each accepted frame. Every cycle, the DUT
// outputs are checked against the head of that queue.
module tb_uart_tx_ctrl;

  localparam int unsigned W = 8;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic [W-1:0] p_data;
  logic         data_valid;
  logic         par_en;
  logic         par_typ;
  logic [1:0]   mux_sel;
  logic         ser_data;
  logic         par_bit;
  logic         busy;

  uart_tx_ctrl #(.DATA_WIDTH(W)) dut (
    .CLK        (clk),
    .RST        (rst),
    .P_DATA     (p_data),
    .Data_Valid (data_valid),
    .PAR_EN     (par_en),
    .PAR_TYP    (par_typ),
    .mux_sel    (mux_sel),
    .ser_data   (ser_data),
    .par_bit    (par_bit),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int busy_cycles = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: a frame is a list of line symbols (mux code, data bit).
  typedef struct {
    logic [1:0] mux;
    logic       ser;
  } slot_t;

  slot_t      exp_q[$];
  logic [1:0] m_mux  = 2'b01;
  logic       m_ser  = 1'b0;
  logic       m_busy = 1'b0;
  logic       m_par  = 1'b0;

  task automatic model_edge();
    slot_t s;
    if (rst) begin
      exp_q.delete();
      m_mux = 2'b01; m_ser = 1'b0; m_busy = 1'b0; m_par = 1'b0;
    end else begin
      // New frames are only taken when nothing more is pending (idle or last STOP).
      if (exp_q.size() == 0 && data_valid) begin
        s.mux = 2'b00; s.ser = 1'b0; exp_q.push_back(s);
        for (int i = 0; i < int'(W); i++) begin
          s.mux = 2'b10; s.ser = p_data[i]; exp_q.push_back(s);
        end
        if (PAR_BUILT && par_en) begin
          s.mux = 2'b11; s.ser = 1'b0; exp_q.push_back(s);
        end
        s.mux = 2'b01; s.ser = 1'b0; exp_q.push_back(s);
        if (PAR_BUILT) m_par = (^p_data) ^ par_typ;
      end
      if (exp_q.size() != 0) begin
        s = exp_q.pop_front();
        m_mux = s.mux; m_ser = s.ser; m_busy = 1'b1;
      end else begin
        m_mux = 2'b01; m_ser = 1'b0; m_busy = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("mux_sel",  32'(mux_sel),  32'(m_mux));
    check_eq("ser_data", 32'(ser_data), 32'(m_ser));
    check_eq("busy",     32'(busy),     32'(m_busy));
    check_eq("par_bit",  32'(par_bit),  32'(m_par));
    if (busy) busy_cycles++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1; p_data = '0; data_valid = 1'b0; par_en = 1'b0; par_typ = 1'b0;

    // Reset for two cycles.
    steps(2);
    check_eq("reset_mux", 32'(mux_sel), 32'h1);
    check_eq("reset_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    steps(2);

    // No-parity frame, 0xA5.
    p_data = 8'hA5; par_en = 1'b0; data_valid = 1'b1; busy_cycles = 0;
    step();
    data_valid = 1'b0; p_data = 8'hFF;
    steps(13);
    check_eq("len_nopar", 32'(busy_cycles), 32'd10);

    // Even parity, 0x07.
    p_data = 8'h07; par_en = 1'b1; par_typ = 1'b0; data_valid = 1'b1; busy_cycles = 0;
    step();
    data_valid = 1'b0; par_typ = 1'b1; par_en = 1'b0;
    check_eq("par_even", 32'(par_bit), PAR_BUILT ? 32'h1 : 32'h0);
    steps(13);
    check_eq("len_par", 32'(busy_cycles), PAR_BUILT ? 32'd11 : 32'd10);

    // Odd parity, 0x07.
    p_data = 8'h07; par_en = 1'b1; par_typ = 1'b1; data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    check_eq("par_odd", 32'(par_bit), 32'h0);
    steps(13);

    // Back-to-back: valid held high, 0x3C then 0xC3; busy must never drop.
    par_en = 1'b0; p_data = 8'h3C; data_valid = 1'b1; busy_cycles = 0;
    step();
    p_data = 8'hC3;
    steps(19);
    check_eq("b2b_busy", 32'(busy_cycles), 32'd20);
    data_valid = 1'b0;
    steps(12);

    // Reset in the 4th DATA cycle, then a clean frame.
    p_data = 8'h5A; data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    steps(4);
    rst = 1'b1;
    step();
    check_eq("midrst_mux", 32'(mux_sel), 32'h1);
    rst = 1'b0;
    steps(2);
    p_data = 8'h96; par_en = 1'b1; par_typ = 1'b0; data_valid = 1'b1; busy_cycles = 0;
    step();
    data_valid = 1'b0;
    steps(13);
    check_eq("after_rst_len", 32'(busy_cycles), PAR_BUILT ? 32'd11 : 32'd10);

    // Randomised traffic, including occasional resets.
    for (int i = 0; i < 600; i++) begin
      rst        = ($urandom_range(80) == 0);
      data_valid = ($urandom_range(3) != 0);
      p_data     = W'($urandom);
      par_en     = 1'($urandom);
      par_typ    = 1'($urandom);
      step();
    end
    rst = 1'b0; data_valid = 1'b0;
    steps(14);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
